// File: rtl/slot_dispatcher_pkg.sv
// Shared constants for the slot dispatcher slice.
package slot_dispatcher_pkg;

    localparam bit Enable  = 1'b1;
    localparam bit Disable = 1'b0;

endpackage

// File: rtl/slot_dispatcher_pick.sv
// Find-first-free selector: a log-depth tree of 2:1 pickers over the free bitmap.
module dispatcher_pick
    import slot_dispatcher_pkg::*;
#(
    parameter  int OUT      = 8,
    parameter  bit MSB      = Disable,
    localparam int LOG2_OUT = $clog2(OUT)
) (
    input  logic [OUT-1:0]      free,
    output logic                found,
    output logic [LOG2_OUT-1:0] idx
);

    localparam int unsigned LEAVES = 1 << LOG2_OUT;
    localparam int unsigned NODES  = 2 * LEAVES - 1;

    logic                node_found [NODES];
    logic [LOG2_OUT-1:0] node_idx   [NODES];

    // Heap layout: node n has children 2n+1 / 2n+2; leaves padded past OUT are never free.
    always_comb begin
        for (int unsigned i = 0; i < NODES; i++) begin
            node_found[i] = 1'b0;
            node_idx[i]   = '0;
        end
        for (int unsigned i = 0; i < LEAVES; i++) begin
            node_found[LEAVES-1+i] = (i < OUT) ? free[i] : 1'b0;
            node_idx[LEAVES-1+i]   = LOG2_OUT'(i);
        end
        for (int unsigned k = 0; k < LEAVES - 1; k++) begin
            int unsigned n;
            logic        take_right;
            n          = LEAVES - 2 - k;
            take_right = MSB ? node_found[2*n+2] : !node_found[2*n+1];
            node_found[n] = node_found[2*n+1] | node_found[2*n+2];
            node_idx[n]   = take_right ? node_idx[2*n+2] : node_idx[2*n+1];
        end
    end

    assign found = node_found[0];
    assign idx   = node_idx[0];

endmodule

// File: rtl/slot_dispatcher.sv
// Dispatches a valid/ready stream into the first free of OUT slots; slots are freed by release bits.
module slot_dispatcher
    import slot_dispatcher_pkg::*;
#(
    parameter  int DATA     = 8,
    parameter  int OUT      = 8,
    parameter  bit MSB      = Disable,
    localparam int LOG2_OUT = $clog2(OUT)
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      in_valid,
    input  logic [DATA-1:0]           in_data,
    output logic                      in_ready,
    output logic [LOG2_OUT-1:0]       alloc_idx,
    output logic [OUT-1:0]            slot_valid,
    output logic [OUT-1:0][DATA-1:0]  slot_data,
    input  logic [OUT-1:0]            slot_release,
    output logic [LOG2_OUT:0]         count,
    output logic                      full,
    output logic                      empty
);

    logic [OUT-1:0]           valid_q;
    logic [OUT-1:0][DATA-1:0] data_q;
    logic [LOG2_OUT:0]        count_q;

    logic                found;
    logic [LOG2_OUT-1:0] pick_idx;
    logic                accept;
    logic [OUT-1:0]      rel;
    logic [OUT-1:0]      alloc_oh;
    logic [OUT-1:0]      valid_d;
    logic [LOG2_OUT:0]   rel_cnt;
    logic [LOG2_OUT:0]   count_d;

    dispatcher_pick #(
        .OUT (OUT),
        .MSB (MSB)
    ) u_pick (
        .free  (~valid_q),
        .found (found),
        .idx   (pick_idx)
    );

    assign full     = (count_q == (LOG2_OUT+1)'(OUT));
    assign empty    = (count_q == '0);
    // Ready comes from registered occupancy only; held low while reset is asserted.
    assign in_ready = reset_ && !full;
    assign accept   = in_valid && in_ready && found;

    always_comb begin
        rel      = slot_release & valid_q;
        alloc_oh = '0;
        if (accept) begin
            alloc_oh[pick_idx] = 1'b1;
        end
        valid_d = (valid_q & ~rel) | alloc_oh;
        rel_cnt = '0;
        for (int unsigned i = 0; i < OUT; i++) begin
            rel_cnt = rel_cnt + (LOG2_OUT+1)'(rel[i]);
        end
        count_d = count_q + (LOG2_OUT+1)'(accept) - rel_cnt;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            valid_q <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            if (accept) begin
                data_q[pick_idx] <= in_data;
            end
        end
    end

    assign alloc_idx  = pick_idx;
    assign slot_valid = valid_q;
    assign slot_data  = data_q;
    assign count      = count_q;

endmodule
